// File: rtl/serv_dbus_pkg.sv
// Shared definitions for the data-bus controller: FSM encoding and Wishbone widths.
package serv_dbus_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/serv_dbus_timeout.sv
// Wait-state counter for an outstanding bus cycle. tc_o flags the last allowed cycle.
module serv_dbus_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/serv_dbus_ctrl.sv
// Data-bus transaction controller: one Wishbone classic cycle per core load/store,
// registered response pulses, and an optional watchdog on slave hangs.
module serv_dbus_ctrl
  import serv_dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_dat,
  input  logic [SW-1:0] i_sel,
  input  logic          i_misalign,
  output logic [DW-1:0] o_rdt,
  output logic          o_ack,
  output logic          o_err,
  output logic          o_busy,
  output logic [AW-1:0] o_wb_adr,
  output logic [DW-1:0] o_wb_dat,
  output logic [SW-1:0] o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [DW-1:0] i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);

  state_e        state_q, state_d;
  logic [DW-1:0] rdt_q, rdt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          cnt_clr, cnt_en, cnt_tc;

  // Word-aligned bus: the byte offset is already encoded in i_sel.
  logic unused_adr;
  assign unused_adr = ^i_adr[1:0];

  always_comb begin
    state_d = state_q;
    rdt_d   = rdt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (i_misalign) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            adr_d   = {i_adr[AW-1:2], 2'b00};
            dat_d   = i_dat;
            sel_d   = i_sel;
            we_d    = i_we;
            cyc_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Error takes priority over a coincident ack.
        if (i_wb_err) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          if (!we_q) begin
            rdt_d = i_wb_rdt;
          end
          state_d = ST_RESP;
        end else if (cnt_tc) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rdt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdt_q   <= rdt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_tmo
      serv_dbus_timeout #(
        .TIMEOUT(TIMEOUT),
        .CW     (CW)
      ) u_timeout (
        .clk_i(i_clk),
        .rst_i(i_rst),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .tc_o (cnt_tc)
      );
    end else begin : g_no_tmo
      logic unused_cnt;
      assign unused_cnt = cnt_clr ^ cnt_en;
      assign cnt_tc     = 1'b0;
    end
  endgenerate

  assign o_rdt    = rdt_q;
  assign o_ack    = ack_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_wb_we  = we_q;
  assign o_wb_cyc = cyc_q;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Directed bench for serv_dbus_ctrl with a 4-cycle bus watchdog.
module tb_serv_dbus_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_adr = '0;
  logic [31:0] i_dat = '0;
  logic [3:0]  i_sel = '0;
  logic        i_misalign = 1'b0;
  logic [31:0] o_rdt;
  logic        o_ack, o_err, o_busy;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc;
  logic [31:0] i_wb_rdt = '0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Event counters sampled on the rising edge (values from the previous cycle).
  int   bus_cnt = 0;
  int   ack_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  logic cyc_prev = 1'b0;
  int   b0, a0, e0;

  always #5 clk = ~clk;

  serv_dbus_ctrl #(.TIMEOUT(4), .CW(8)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_adr     (i_adr),
    .i_dat     (i_dat),
    .i_sel     (i_sel),
    .i_misalign(i_misalign),
    .o_rdt     (o_rdt),
    .o_ack     (o_ack),
    .o_err     (o_err),
    .o_busy    (o_busy),
    .o_wb_adr  (o_wb_adr),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .o_wb_we   (o_wb_we),
    .o_wb_cyc  (o_wb_cyc),
    .i_wb_rdt  (i_wb_rdt),
    .i_wb_ack  (i_wb_ack),
    .i_wb_err  (i_wb_err)
  );

  always @(posedge clk) begin
    cyc_prev <= o_wb_cyc;
    if (o_wb_cyc && !cyc_prev) bus_cnt <= bus_cnt + 1;
    if (o_ack) ack_cnt <= ack_cnt + 1;
    if (o_err) err_cnt <= err_cnt + 1;
    if (o_ack && o_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic snap();
    b0 = bus_cnt;
    a0 = ack_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_cyc",  32'(o_wb_cyc), 0);
    check("rst_ack",  32'(o_ack),    0);
    check("rst_err",  32'(o_err),    0);
    check("rst_busy", 32'(o_busy),   0);
    check("rst_we",   32'(o_wb_we),  0);
    check("rst_rdt",  o_rdt,         0);
    check("rst_adr",  o_wb_adr,      0);
    check("rst_dat",  o_wb_dat,      0);
    check("rst_sel",  32'(o_wb_sel), 0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // Load with two wait states
    snap();
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_1003; i_sel = 4'b1000; i_misalign = 1'b0;
    tick();
    i_req = 1'b0; i_adr = 32'hFFFF_FFFF; i_sel = 4'hF; i_we = 1'b1;
    check("ld_cyc1", 32'(o_wb_cyc), 1);
    check("ld_adr",  o_wb_adr, 32'h0000_1000);
    check("ld_sel",  32'(o_wb_sel), 32'h8);
    check("ld_we",   32'(o_wb_we), 0);
    check("ld_busy", 32'(o_busy), 1);
    tick();
    check("ld_cyc2", 32'(o_wb_cyc), 1);
    check("ld_adr_hold", o_wb_adr, 32'h0000_1000);
    tick();
    check("ld_cyc3", 32'(o_wb_cyc), 1);
    i_wb_ack = 1'b1; i_wb_rdt = 32'hDEAD_BEEF;
    tick();
    i_wb_ack = 1'b0; i_wb_rdt = '0;
    check("ld_ack",    32'(o_ack), 1);
    check("ld_noerr",  32'(o_err), 0);
    check("ld_cycoff", 32'(o_wb_cyc), 0);
    check("ld_rdt",    o_rdt, 32'hDEAD_BEEF);
    tick();
    check("ld_ackend", 32'(o_ack), 0);
    check("ld_idle",   32'(o_busy), 0);
    check("ld_nbus",   32'(bus_cnt - b0), 1);
    check("ld_nack",   32'(ack_cnt - a0), 1);
    $display("load  adr=%h rdt=%h", o_wb_adr, o_rdt);

    // Zero-wait store
    snap();
    i_req = 1'b1; i_we = 1'b1; i_adr = 32'h0000_2000; i_dat = 32'h1234_5678; i_sel = 4'b1111;
    tick();
    i_req = 1'b0; i_we = 1'b0; i_dat = '0; i_sel = 4'b0001;
    check("st_cyc", 32'(o_wb_cyc), 1);
    check("st_we",  32'(o_wb_we), 1);
    check("st_dat", o_wb_dat, 32'h1234_5678);
    check("st_sel", 32'(o_wb_sel), 32'hF);
    i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFE_F00D;
    tick();
    i_wb_ack = 1'b0; i_wb_rdt = '0;
    check("st_ack",    32'(o_ack), 1);
    check("st_cycoff", 32'(o_wb_cyc), 0);
    check("st_rdt",    o_rdt, 32'hDEAD_BEEF);
    tick();
    check("st_idle",   32'(o_busy), 0);
    check("st_nack",   32'(ack_cnt - a0), 1);
    $display("store adr=%h dat=%h", o_wb_adr, o_wb_dat);

    // Misaligned request: no bus cycle, single error pulse
    snap();
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_3001; i_misalign = 1'b1;
    tick();
    i_req = 1'b0; i_misalign = 1'b0;
    check("mis_err",  32'(o_err), 1);
    check("mis_ack",  32'(o_ack), 0);
    check("mis_cyc",  32'(o_wb_cyc), 0);
    check("mis_busy", 32'(o_busy), 1);
    tick();
    check("mis_errend", 32'(o_err), 0);
    check("mis_idle",   32'(o_busy), 0);
    check("mis_nbus",   32'(bus_cnt - b0), 0);
    check("mis_nerr",   32'(err_cnt - e0), 1);
    $display("misal err pulses=%0d", err_cnt - e0);

    // Timeout with a silent slave
    snap();
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_4000; i_sel = 4'b0011;
    tick();
    i_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("to_cyc%0d", k), 32'(o_wb_cyc), 1);
      check($sformatf("to_err%0d", k), 32'(o_err), 0);
      tick();
    end
    check("to_cycoff", 32'(o_wb_cyc), 0);
    check("to_err",    32'(o_err), 1);
    check("to_ack",    32'(o_ack), 0);
    tick();
    check("to_idle",   32'(o_busy), 0);
    check("to_nerr",   32'(err_cnt - e0), 1);
    $display("tmout err pulses=%0d", err_cnt - e0);

    // Next request after timeout is accepted
    snap();
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_5004; i_sel = 4'b1111;
    tick();
    i_req = 1'b0;
    check("rt_cyc", 32'(o_wb_cyc), 1);
    check("rt_adr", o_wb_adr, 32'h0000_5004);
    i_wb_ack = 1'b1; i_wb_rdt = 32'hA5A5_5A5A;
    tick();
    i_wb_ack = 1'b0; i_wb_rdt = '0;
    check("rt_ack", 32'(o_ack), 1);
    check("rt_rdt", o_rdt, 32'hA5A5_5A5A);
    tick();
    $display("retry adr=%h rdt=%h", o_wb_adr, o_rdt);

    // Simultaneous ack+err with i_req held during BUS
    snap();
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_6000; i_sel = 4'b0100;
    tick();
    i_adr = 32'h0000_7000;
    check("ae_cyc", 32'(o_wb_cyc), 1);
    check("ae_adr", o_wb_adr, 32'h0000_6000);
    i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_rdt = 32'h1111_2222;
    tick();
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rdt = '0;
    i_req = 1'b0;
    check("ae_err", 32'(o_err), 1);
    check("ae_ack", 32'(o_ack), 0);
    check("ae_rdt", o_rdt, 32'hA5A5_5A5A);
    tick();
    tick();
    check("ae_idle",  32'(o_busy), 0);
    check("ae_nbus",  32'(bus_cnt - b0), 1);
    check("ae_nack",  32'(ack_cnt - a0), 0);
    check("ae_nerr",  32'(err_cnt - e0), 1);
    check("ae_both",  32'(both_cnt), 0);
    $display("ackerr err pulses=%0d ack pulses=%0d", err_cnt - e0, ack_cnt - a0);

    // Asynchronous reset in the middle of a bus cycle
    snap();
    i_req = 1'b1; i_we = 1'b1; i_adr = 32'h0000_8000; i_dat = 32'h5555_AAAA; i_sel = 4'hF;
    tick();
    i_req = 1'b0;
    check("ar_cyc_pre", 32'(o_wb_cyc), 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("ar_cyc",  32'(o_wb_cyc), 0);
    check("ar_busy", 32'(o_busy), 0);
    check("ar_ack",  32'(o_ack), 0);
    check("ar_err",  32'(o_err), 0);
    check("ar_adr",  o_wb_adr, 0);
    tick();
    i_rst = 1'b0;
    i_wb_ack = 1'b1; i_wb_err = 1'b1;
    tick();
    tick();
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    tick();
    check("ar_cyc_post",  32'(o_wb_cyc), 0);
    check("ar_busy_post", 32'(o_busy), 0);
    check("ar_nack",      32'(ack_cnt - a0), 0);
    check("ar_nerr",      32'(err_cnt - e0), 0);
    $display("areset cyc=%0d busy=%0d", o_wb_cyc, o_busy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
